// File: rtl/osc_ctrl_pkg.sv
// Shared types and constants for the oscillator power sequencer.
package osc_ctrl_pkg;

   // Sequencer states; encoding is exported on the debug state output.
   typedef enum logic [2:0] {
      OFF    = 3'd0,
      SETTLE = 3'd1,
      ON     = 3'd2,
      IDLE   = 3'd3,
      COOL   = 3'd4
   } osc_state_t;

   // Level that powers the oscillator on its enable pin.
   localparam logic ACTIVE_LOW = 1'b0;

   // Width of the shared state timer.
   localparam int CNT_W = 8;

   // Largest of three timing parameters, used for the width check.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/osc_power_sequencer_if.sv
// Requester/status bundle between the oscillator sequencer and its users.
interface osc_power_sequencer_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0] req;
   logic               force_on;
   logic [NUM_REQ-1:0] ack;
   logic               osc_power_n;
   logic               osc_stable;
   logic [2:0]         state;

   // Requester side: raises requests, observes grants and oscillator status.
   modport master (
      output req,
      output force_on,
      input  ack,
      input  osc_power_n,
      input  osc_stable,
      input  state
   );

   // Sequencer side.
   modport slave (
      input  req,
      input  force_on,
      output ack,
      output osc_power_n,
      output osc_stable,
      output state
   );
endinterface

// File: rtl/osc_ctrl_timer.sv
// Clearable saturating up-counter with a terminal-count compare.
module osc_ctrl_timer
   import osc_ctrl_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic [CNT_W-1:0] tc_value,
   output logic             tc
);

   logic [CNT_W-1:0] count_q;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   // Count up every cycle; restart from zero whenever the owner changes state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else begin
         count_q <= sat_inc(count_q);
      end
   end

   assign tc = (count_q == tc_value);

endmodule

// File: rtl/osc_power_sequencer.sv
// Oscillator power sequencer: powers the oscillator on first request, waits
// for it to settle, grants requesters, and powers down after an idle timeout
// with an enforced minimum off time. Runs on the always-on system clock.
module osc_power_sequencer
   import osc_ctrl_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int SETTLE_CYCLES  = 16,
   parameter int IDLE_CYCLES    = 32,
   parameter int OFF_MIN_CYCLES = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   osc_power_sequencer_if.slave  bus
);

   localparam int MAX_T = max3(SETTLE_CYCLES, IDLE_CYCLES, OFF_MIN_CYCLES);

   // Parameter sanity, caught at elaboration.
   if (CNT_W < $clog2(MAX_T)) begin : g_cnt_w_chk
      $error("osc_power_sequencer: CNT_W too narrow for timing parameters");
   end
   if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_num_req_chk
      $error("osc_power_sequencer: NUM_REQ must be 1..8");
   end
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
       IDLE_CYCLES < 1 || IDLE_CYCLES > 255 ||
       OFF_MIN_CYCLES < 1 || OFF_MIN_CYCLES > 255) begin : g_timing_chk
      $error("osc_power_sequencer: timing parameters must be 1..255");
   end

   localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] IDLE_TC   = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] COOL_TC   = CNT_W'(OFF_MIN_CYCLES - 1);

   osc_state_t         state_q;
   osc_state_t         state_d;
   logic               any_req;
   logic               timer_clear;
   logic [CNT_W-1:0]   tc_value;
   logic               tc;
   logic               power_n_q;
   logic               power_n_d;
   logic               stable_q;
   logic               stable_d;
   logic [NUM_REQ-1:0] ack_q;
   logic [NUM_REQ-1:0] ack_d;

   assign any_req = (|bus.req) | bus.force_on;

   osc_ctrl_timer u_timer (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (timer_clear),
      .tc_value (tc_value),
      .tc       (tc)
   );

   // Next state, timer compare selection and next values of registered outputs.
   always_comb begin
      state_d  = state_q;
      tc_value = '0;
      unique case (state_q)
         OFF: begin
            if (any_req) state_d = SETTLE;
         end
         SETTLE: begin
            // Dropped requests do not abort the settle; ON then falls to IDLE.
            tc_value = SETTLE_TC;
            if (tc) state_d = ON;
         end
         ON: begin
            if (!any_req) state_d = IDLE;
         end
         IDLE: begin
            // A request on the expiry cycle keeps the oscillator running.
            tc_value = IDLE_TC;
            if (any_req)  state_d = ON;
            else if (tc)  state_d = COOL;
         end
         COOL: begin
            // Requests stay pending until the minimum off time has elapsed.
            tc_value = COOL_TC;
            if (tc) state_d = OFF;
         end
         default: state_d = OFF;
      endcase

      timer_clear = (state_d != state_q);

      power_n_d = (state_d == SETTLE || state_d == ON || state_d == IDLE)
                  ? ACTIVE_LOW : ~ACTIVE_LOW;
      stable_d  = (state_d == ON || state_d == IDLE);
      // Grants track requests only while ON; leaving ON implies no requests.
      ack_d     = (state_q == ON) ? bus.req : '0;
   end

   // State and output registers; reset forces the oscillator off at once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= OFF;
         power_n_q <= ~ACTIVE_LOW;
         stable_q  <= 1'b0;
         ack_q     <= '0;
      end else begin
         state_q   <= state_d;
         power_n_q <= power_n_d;
         stable_q  <= stable_d;
         ack_q     <= ack_d;
      end
   end

   assign bus.osc_power_n = power_n_q;
   assign bus.osc_stable  = stable_q;
   assign bus.ack         = ack_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_osc_power_sequencer.sv
// Directed bench for the oscillator power sequencer (default parameters).
module tb_osc_power_sequencer;
   import osc_ctrl_pkg::*;

   logic clock;
   logic reset_n;
   int   total;
   int   passed;

   osc_power_sequencer_if #(.NUM_REQ(4)) bus ();

   osc_power_sequencer #(
      .NUM_REQ        (4),
      .SETTLE_CYCLES  (16),
      .IDLE_CYCLES    (32),
      .OFF_MIN_CYCLES (8)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance n rising edges, then return at the following falling edge.
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n      = 1'b0;
      bus.req      = 4'b0000;
      bus.force_on = 1'b0;
      repeat (3) @(negedge clock);
      total++; if (bus.state !== 3'd0) $display("FAIL rst_state: got %0d want 0", bus.state); else passed++;
      total++; if (bus.osc_power_n !== 1'b1) $display("FAIL rst_power_n: got %b want 1", bus.osc_power_n); else passed++;
      total++; if (bus.osc_stable !== 1'b0) $display("FAIL rst_stable: got %b want 0", bus.osc_stable); else passed++;
      total++; if (bus.ack !== 4'b0000) $display("FAIL rst_ack: got %b want 0000", bus.ack); else passed++;
      reset_n = 1'b1;
      step(2);
      total++; if (bus.state !== 3'd0) $display("FAIL rst_idle_off: got %0d want 0", bus.state); else passed++;
   endtask

   task automatic test_powerup();
      bus.req = 4'b0001;
      step(1);  // edge 0
      total++; if (bus.osc_power_n !== 1'b0) $display("FAIL pu_power_n: got %b want 0", bus.osc_power_n); else passed++;
      total++; if (bus.state !== 3'd1) $display("FAIL pu_settle: got %0d want 1", bus.state); else passed++;
      step(15); // edge 15
      total++; if (bus.osc_stable !== 1'b0) $display("FAIL pu_early_stable: got %b want 0", bus.osc_stable); else passed++;
      step(1);  // edge 16
      total++; if (bus.osc_stable !== 1'b1) $display("FAIL pu_stable: got %b want 1", bus.osc_stable); else passed++;
      total++; if (bus.state !== 3'd2) $display("FAIL pu_on: got %0d want 2", bus.state); else passed++;
      total++; if (bus.ack !== 4'b0000) $display("FAIL pu_ack_early: got %b want 0000", bus.ack); else passed++;
      step(1);  // edge 17
      total++; if (bus.ack !== 4'b0001) $display("FAIL pu_ack: got %b want 0001", bus.ack); else passed++;
   endtask

   task automatic test_ack_follow();
      bus.req = 4'b0011;
      step(1);
      total++; if (bus.ack !== 4'b0011) $display("FAIL af_two: got %b want 0011", bus.ack); else passed++;
      bus.req = 4'b0010;
      step(1);
      total++; if (bus.ack !== 4'b0010) $display("FAIL af_drop0: got %b want 0010", bus.ack); else passed++;
      bus.req = 4'b0000;
      step(1);
      total++; if (bus.ack !== 4'b0000) $display("FAIL af_drop_all: got %b want 0000", bus.ack); else passed++;
      total++; if (bus.state !== 3'd3) $display("FAIL af_idle: got %0d want 3", bus.state); else passed++;
      total++; if (bus.osc_stable !== 1'b1) $display("FAIL af_stable: got %b want 1", bus.osc_stable); else passed++;
   endtask

   // Entered with IDLE state just reached (idle counter 0).
   task automatic test_idle_expiry();
      step(31);
      total++; if (bus.state !== 3'd3) $display("FAIL ie_still_idle: got %0d want 3", bus.state); else passed++;
      step(1);
      total++; if (bus.state !== 3'd4) $display("FAIL ie_cool: got %0d want 4", bus.state); else passed++;
      total++; if (bus.osc_power_n !== 1'b1) $display("FAIL ie_power_n: got %b want 1", bus.osc_power_n); else passed++;
      total++; if (bus.osc_stable !== 1'b0) $display("FAIL ie_stable: got %b want 0", bus.osc_stable); else passed++;
      step(3);
      bus.req = 4'b0100;
      step(4);
      total++; if (bus.state !== 3'd4) $display("FAIL ie_cool_hold: got %0d want 4", bus.state); else passed++;
      total++; if (bus.osc_power_n !== 1'b1) $display("FAIL ie_cool_off: got %b want 1", bus.osc_power_n); else passed++;
      step(1);
      total++; if (bus.state !== 3'd0) $display("FAIL ie_off: got %0d want 0", bus.state); else passed++;
      step(1);
      total++; if (bus.state !== 3'd1) $display("FAIL ie_resettle: got %0d want 1", bus.state); else passed++;
      total++; if (bus.osc_power_n !== 1'b0) $display("FAIL ie_repower: got %b want 0", bus.osc_power_n); else passed++;
      step(15);
      total++; if (bus.osc_stable !== 1'b0) $display("FAIL ie_early_stable: got %b want 0", bus.osc_stable); else passed++;
      step(1);
      total++; if (bus.osc_stable !== 1'b1) $display("FAIL ie_stable2: got %b want 1", bus.osc_stable); else passed++;
      total++; if (bus.ack !== 4'b0000) $display("FAIL ie_ack_early: got %b want 0000", bus.ack); else passed++;
      step(1);
      total++; if (bus.ack !== 4'b0100) $display("FAIL ie_ack2: got %b want 0100", bus.ack); else passed++;
   endtask

   task automatic test_idle_rerequest();
      bit stable_dropped;
      stable_dropped = 1'b0;
      bus.req = 4'b0000;
      step(1);
      total++; if (bus.state !== 3'd3) $display("FAIL rr_idle: got %0d want 3", bus.state); else passed++;
      for (int i = 0; i < 31; i++) begin
         step(1);
         if (bus.osc_stable !== 1'b1) stable_dropped = 1'b1;
      end
      bus.req = 4'b0100;  // sampled with idle counter at its expiry value
      step(1);
      if (bus.osc_stable !== 1'b1) stable_dropped = 1'b1;
      total++; if (bus.state !== 3'd2) $display("FAIL rr_on: got %0d want 2", bus.state); else passed++;
      total++; if (bus.osc_power_n !== 1'b0) $display("FAIL rr_power_n: got %b want 0", bus.osc_power_n); else passed++;
      total++; if (bus.ack !== 4'b0000) $display("FAIL rr_ack_early: got %b want 0000", bus.ack); else passed++;
      step(1);
      if (bus.osc_stable !== 1'b1) stable_dropped = 1'b1;
      total++; if (bus.ack !== 4'b0100) $display("FAIL rr_ack: got %b want 0100", bus.ack); else passed++;
      total++; if (stable_dropped !== 1'b0) $display("FAIL rr_stable_glitch: got %b want 0", stable_dropped); else passed++;
   endtask

   task automatic test_pulse();
      bit ack_seen;
      ack_seen = 1'b0;
      bus.req = 4'b0000;
      step(1);   // IDLE
      step(32);  // COOL
      step(8);   // OFF
      total++; if (bus.state !== 3'd0) $display("FAIL pl_off: got %0d want 0", bus.state); else passed++;
      bus.req = 4'b0001;
      step(1);   // edge k: SETTLE
      step(2);   // edges k+1, k+2
      bus.req = 4'b0000;
      for (int i = 0; i < 13; i++) begin
         step(1);
         if (bus.ack !== 4'b0000) ack_seen = 1'b1;
      end
      total++; if (bus.state !== 3'd1) $display("FAIL pl_settle: got %0d want 1", bus.state); else passed++;
      step(1);
      total++; if (bus.state !== 3'd2) $display("FAIL pl_on: got %0d want 2", bus.state); else passed++;
      if (bus.ack !== 4'b0000) ack_seen = 1'b1;
      step(1);
      total++; if (bus.state !== 3'd3) $display("FAIL pl_idle: got %0d want 3", bus.state); else passed++;
      for (int i = 0; i < 32; i++) begin
         step(1);
         if (bus.ack !== 4'b0000) ack_seen = 1'b1;
      end
      total++; if (bus.state !== 3'd4) $display("FAIL pl_cool: got %0d want 4", bus.state); else passed++;
      total++; if (ack_seen !== 1'b0) $display("FAIL pl_ack_seen: got %b want 0", ack_seen); else passed++;
      step(8);
      total++; if (bus.state !== 3'd0) $display("FAIL pl_off2: got %0d want 0", bus.state); else passed++;
   endtask

   task automatic test_force_on_reset();
      bit left_on;
      left_on = 1'b0;
      bus.force_on = 1'b1;
      bus.req      = 4'b0000;
      step(1);
      step(16);
      total++; if (bus.state !== 3'd2) $display("FAIL fo_on: got %0d want 2", bus.state); else passed++;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (bus.state !== 3'd2 || bus.ack !== 4'b0000) left_on = 1'b1;
      end
      total++; if (left_on !== 1'b0) $display("FAIL fo_hold: got %b want 0", left_on); else passed++;
      bus.req = 4'b0001;
      step(2);
      total++; if (bus.ack !== 4'b0001) $display("FAIL fo_ack: got %b want 0001", bus.ack); else passed++;
      #2 reset_n = 1'b0;
      #1;
      total++; if (bus.osc_power_n !== 1'b1) $display("FAIL ar_power_n: got %b want 1", bus.osc_power_n); else passed++;
      total++; if (bus.osc_stable !== 1'b0) $display("FAIL ar_stable: got %b want 0", bus.osc_stable); else passed++;
      total++; if (bus.ack !== 4'b0000) $display("FAIL ar_ack: got %b want 0000", bus.ack); else passed++;
      total++; if (bus.state !== 3'd0) $display("FAIL ar_state: got %0d want 0", bus.state); else passed++;
      @(negedge clock);
      bus.force_on = 1'b0;
      bus.req      = 4'b0000;
      reset_n      = 1'b1;
      step(2);
      total++; if (bus.state !== 3'd0) $display("FAIL ar_stay_off: got %0d want 0", bus.state); else passed++;
   endtask

   initial begin
      total  = 0;
      passed = 0;
      test_reset();
      test_powerup();
      test_ack_follow();
      test_idle_expiry();
      test_idle_rerequest();
      test_pulse();
      test_force_on_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/osc_power_sequencer.md
Name: osc_power_sequencer

Overview:
- Controller for the on-board oscillator.
- Drives its active-low power enable and tells downstream logic when the oscillator output is stable and usable.
- Shares the oscillator among NUM_REQ requesters: it powers up on the first request, waits a settle time, then acknowledges requesters.
- After an idle timeout it powers the oscillator down and enforces a minimum off time.
- Runs on the always-on system clock, not on the oscillator output.

Parameters:
- NUM_REQ, 4: number of requesters; 1..8.
- SETTLE_CYCLES, 16: cycles between power-on and the stable indication; 1..255.
- IDLE_CYCLES, 32: cycles with no request before power-down; 1..255.
- OFF_MIN_CYCLES, 8: minimum powered-off cycles before re-power; 1..255.

Ports:
- clock  input  1  always-on system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester level request for the oscillator.
- force_on  input  1  keeps the oscillator powered and in ON while high; counts as a request.
- ack  output  NUM_REQ  per-requester grant: oscillator is stable and held on.
- osc_power_n  output  1  oscillator power enable, active-low (0 = powered).
- osc_stable  output  1  oscillator output is valid; used as the downstream clock-gate enable.
- state  output  3  current FSM state encoding, for debug.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clock deassert by the caller):
  - state = OFF, osc_power_n = 1, osc_stable = 0, ack = 0, counter = 0.
- Reset mid-operation: outputs drop to reset values immediately, without waiting for a clock edge.
- Let any_req = |req | force_on, sampled each rising edge.
- All outputs are registered. The FSM has five states:

- OFF: osc_power_n = 1, osc_stable = 0.
  - any_req = 1 -> SETTLE, counter cleared, osc_power_n = 0 from that edge.
- SETTLE: osc_power_n = 0, osc_stable = 0, counter increments each cycle.
  - At counter == SETTLE_CYCLES-1 -> ON, osc_stable = 1 from that edge.
  - Requests dropping during SETTLE do not abort it; the FSM still goes to ON, then to IDLE.
- ON: osc_power_n = 0, osc_stable = 1.
  - ack[i] <= req[i] on every edge while in ON.
  - any_req = 0 -> IDLE, counter cleared, ack cleared on the same edge.
- IDLE: osc_power_n = 0, osc_stable = 1, ack = 0, counter increments.
  - any_req = 1 -> ON. ack rises one edge later, with no settle delay.
  - Counter == IDLE_CYCLES-1 with any_req = 0 -> COOL, counter cleared, osc_power_n = 1 and osc_stable = 0 on that same edge.
  - A request arriving on the expiry cycle wins: the transition is to ON.
- COOL: osc_power_n = 1, osc_stable = 0, counter increments; requests are ignored but stay pending (level-sensitive).
  - At counter == OFF_MIN_CYCLES-1 -> OFF.
  - If any_req is still high, OFF leaves on the next edge (normal OFF rule).

- ack rules:
  - ack[i] is never high unless osc_stable is high.
  - ack[i] follows req[i] with 1-cycle latency only in ON.
  - A requester dropping req while others remain causes only its own ack to fall on the next edge.
- Latency: req rising while in OFF, sampled at edge k:
  - osc_power_n = 0 after edge k.
  - osc_stable = 1 after edge k+SETTLE_CYCLES.
  - ack = 1 after edge k+SETTLE_CYCLES+1.
- Counter: one shared 8-bit up-counter, cleared on every state change, saturating at 255.
- Parameter check: elaboration-time assertion that the counter width ≥ $clog2 of the maximum of the three timing parameters.

Decomposition:
- Package osc_ctrl_pkg:
  - state enum osc_state_t: OFF=0, SETTLE=1, ON=2, IDLE=3, COOL=4.
  - ACTIVE_LOW constant (1'b0).
  - counter width constant CNT_W = 8.
- One natural sub-module, osc_ctrl_timer: clearable saturating counter with a terminal-count compare input; instantiated once.
- FSM and ack registers live in the top module.

Test Plan:
- Reset, then req=4'b0001 held from edge 0 -> osc_power_n=0 after edge 0; osc_stable=1 after edge 16; ack=4'b0001 after edge 17; state=ON.
- In ON with req=4'b0011, drop req[0] -> ack=4'b0010 next edge; then drop all -> ack=0 next edge, state=IDLE, osc_stable stays 1.
- Idle expiry: no requests for 32 cycles in IDLE -> osc_power_n=1, osc_stable=0, state=COOL. Raise req[2] at cool cycle 3 -> held until COOL ends after 8 cycles; OFF then SETTLE on the following edges; ack[2] = 1 after the 16-cycle settle plus 1.
- Re-request in IDLE at idle cycle 31 (the expiry cycle) -> state=ON, no power drop, ack rises next edge, osc_stable never falls.
- req pulse of 3 cycles in OFF -> full 16-cycle SETTLE, ON with ack=0, IDLE, COOL after 32 cycles; ack never asserts.
- force_on=1, req=0 -> reaches ON and stays for ≥100 cycles with ack=0. Assert reset_n=0 mid-ON, between clock edges -> osc_power_n=1, osc_stable=0, ack=0 immediately, before the next edge.
